mem_bridge: RTL and testbench

- Sits directly downstream of the CPU memory port; converts CPU byte/half/word accesses into word-addressed, byte-enabled RAM transactions.
- Handles lane steering and read-data alignment.
- Splits misaligned accesses into two word beats.
- Asserts busy so the CPU control unit can hold pc_clk/rd_clk until the access completes.

---
 rtl/mem_bridge.sv | 170 +++++++++++++++++
 tb/tb_mem_bridge.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bridge.sv
// CPU-to-RAM bridge: converts byte/half/word accesses into word-addressed,
// byte-enabled RAM beats, splitting misaligned accesses into two beats.
module mem_bridge #(
    parameter int AW     = 32,
    parameter int RAM_AW = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_strobe,
    input  logic              rd_req,
    input  logic [1:0]        mem_size,
    input  logic [AW-1:0]     addr,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    output logic              busy,
    output logic              done,
    output logic              drop_err,
    output logic              ram_req,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [3:0]        ram_be,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic              ram_ack
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

    state_t          state_q, state_d;
    logic            strobe_q;
    logic [AW-1:0]   addr_q, addr_d;
    logic [1:0]      size_q, size_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            we_q, we_d;
    logic [63:0]     rd64_q, rd64_d;
    logic [31:0]     data_o_q, data_o_d;
    logic            drop_err_q, drop_err_d;

    logic            wr_edge;
    logic            req_any;
    logic [1:0]      off;
    logic [3:0]      mask;
    logic [7:0]      be64;
    logic [63:0]     wd64;
    logic            split;
    logic [RAM_AW-1:0] word_addr;
    logic [31:0]     rd_shift;

    assign wr_edge   = wr_strobe & ~strobe_q;
    assign req_any   = wr_edge | rd_req;
    assign off       = addr_q[1:0];
    assign word_addr = addr_q[AW-1:2];

    // Lane steering is derived from the captured request so beats stay stable
    always_comb begin
        case (size_q)
            2'b00:   mask = 4'b0001;
            2'b01:   mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        be64     = {4'b0000, mask} << off;
        wd64     = {32'h0, wdata_q} << {off, 3'b000};
        split    = |be64[7:4];
        rd_shift = 32'(rd64_q >> {off, 3'b000});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (req_any && mem_size != 2'b11) state_d = BEAT0;
            BEAT0: if (ram_ack) state_d = split ? BEAT1 : DONE;
            BEAT1: if (ram_ack) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture, rejection and read-data assembly
    always_comb begin
        addr_d     = addr_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        rd64_d     = rd64_q;
        data_o_d   = data_o_q;
        drop_err_d = 1'b0;
        if (state_q == IDLE) begin
            if (req_any) begin
                if (mem_size == 2'b11) begin
                    drop_err_d = 1'b1;
                end else begin
                    addr_d     = addr;
                    size_d     = mem_size;
                    wdata_d    = data_i;
                    we_d       = wr_edge;
                    drop_err_d = wr_edge & rd_req;
                end
            end
        end else begin
            drop_err_d = req_any;
        end
        if (state_q == BEAT0 && ram_ack) rd64_d[31:0]  = ram_rdata;
        if (state_q == BEAT1 && ram_ack) rd64_d[63:32] = ram_rdata;
        if (state_q == DONE && !we_q) begin
            case (size_q)
                2'b00:   data_o_d = {24'h0, rd_shift[7:0]};
                2'b01:   data_o_d = {16'h0, rd_shift[15:0]};
                default: data_o_d = rd_shift;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe_q   <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            rd64_q     <= '0;
            data_o_q   <= '0;
            drop_err_q <= 1'b0;
        end else begin
            strobe_q   <= wr_strobe;
            addr_q     <= addr_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            rd64_q     <= rd64_d;
            data_o_q   <= data_o_d;
            drop_err_q <= drop_err_d;
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        ram_req   = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_be    = '0;
        ram_wdata = '0;
        case (state_q)
            BEAT0: begin
                ram_req   = 1'b1;
                ram_we    = we_q;
                ram_addr  = word_addr;
                ram_be    = be64[3:0];
                ram_wdata = wd64[31:0];
            end
            BEAT1: begin
                ram_req   = 1'b1;
                ram_we    = we_q;
                ram_addr  = word_addr + RAM_AW'(1);
                ram_be    = be64[7:4];
                ram_wdata = wd64[63:32];
            end
            default: ;
        endcase
    end

    assign data_o   = data_o_q;
    assign drop_err = drop_err_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: a RAM responder pops expected beats from
// a scoreboard built by a byte-level model, and load results are checked on done.
module tb_mem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_strobe, rd_req;
    logic [1:0]  mem_size;
    logic [31:0] addr, data_i, data_o;
    logic        busy, done, drop_err;
    logic        ram_req, ram_we;
    logic [29:0] ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata, ram_rdata;
    logic        ram_ack;

    mem_bridge #(.AW(32), .RAM_AW(30)) dut (
        .clk(clk), .reset(reset), .wr_strobe(wr_strobe), .rd_req(rd_req),
        .mem_size(mem_size), .addr(addr), .data_i(data_i), .data_o(data_o),
        .busy(busy), .done(done), .drop_err(drop_err), .ram_req(ram_req),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_be(ram_be),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [29:0] waddr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } beat_t;

    beat_t       beat_q[$];
    logic [31:0] rdexp_q[$];
    logic [31:0] mem [logic [29:0]];
    int          checks = 0;
    int          errors = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    beat_t       held;

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] memRead(input logic [29:0] w);
        if (mem.exists(w)) return mem[w];
        return 32'h0;
    endfunction

    function automatic logic [31:0] laneMask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    // Byte-by-byte model: each byte lands at (addr+i) with 32-bit wrap
    task automatic pushExpected(input bit we, input logic [1:0] size,
                                input logic [31:0] a, input logic [31:0] d);
        int          n;
        beat_t       b0, b1;
        bit          two;
        logic [31:0] ba, wv, rv, wd0, wd1;
        logic [3:0]  be0, be1;
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        two = 1'b0; rv = '0; wd0 = '0; wd1 = '0; be0 = '0; be1 = '0;
        for (int i = 0; i < n; i++) begin
            ba = a + 32'(i);
            wv = memRead(ba[31:2]);
            rv[8*i +: 8] = wv[8*ba[1:0] +: 8];
            if (ba[31:2] == a[31:2]) begin
                be0[ba[1:0]] = 1'b1;
                wd0[8*ba[1:0] +: 8] = d[8*i +: 8];
            end else begin
                two = 1'b1;
                be1[ba[1:0]] = 1'b1;
                wd1[8*ba[1:0] +: 8] = d[8*i +: 8];
                b1.waddr = ba[31:2];
            end
        end
        b0.we = we; b0.waddr = a[31:2]; b0.be = be0; b0.wdata = wd0;
        beat_q.push_back(b0);
        if (two) begin
            b1.we = we; b1.be = be1; b1.wdata = wd1;
            beat_q.push_back(b1);
        end
        if (!we) rdexp_q.push_back(rv);
    endtask

    // RAM responder: acks after ack_delay waiting cycles, checks beats and hold stability
    always @(negedge clk) begin
        beat_t e;
        logic [31:0] m, w;
        if (ram_req && !reset) begin
            m = laneMask(ram_be);
            if (wait_cnt == 0) begin
                held = {ram_we, ram_addr, ram_be, ram_wdata & m};
            end else begin
                checkOutput("beat_hold", {ram_req, ram_we, ram_addr, ram_be, ram_wdata & m},
                            {1'b1, held});
            end
            if (wait_cnt >= ack_delay) begin
                ram_ack  = 1'b1;
                wait_cnt = 0;
                if (beat_q.size() == 0) begin
                    checkOutput("extra_beat", 64'(ram_addr), 64'hFFFF_FFFF);
                end else begin
                    e = beat_q.pop_front();
                    checkOutput("beat_we_addr_be", {ram_we, ram_addr, ram_be},
                                {e.we, e.waddr, e.be});
                    if (e.we) checkOutput("beat_wdata", ram_wdata & laneMask(e.be), e.wdata);
                end
                w = memRead(ram_addr);
                if (ram_we) begin
                    for (int i = 0; i < 4; i++)
                        if (ram_be[i]) w[8*i +: 8] = ram_wdata[8*i +: 8];
                    mem[ram_addr] = w;
                end else begin
                    ram_rdata = w;
                end
            end else begin
                ram_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            ram_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    // Drives one request ahead of a clock edge and measures latency, busy and drops
    task automatic applyStimulus(input bit we, input bit also_rd, input logic [1:0] size,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input int delay, input int collide_at, input int max_cycles,
                                 output int done_at, output int busy_cycles,
                                 output int drops, output int req_cycles);
        @(negedge clk);
        ack_delay = delay;
        mem_size  = size;
        addr      = a;
        data_i    = d;
        if (size != 2'b11) pushExpected(we, size, a, d);
        if (we) wr_strobe = 1'b1;
        if (!we || also_rd) rd_req = 1'b1;
        done_at = -1; busy_cycles = 0; drops = 0; req_cycles = 0;
        for (int c = 1; c <= max_cycles; c++) begin
            @(negedge clk);
            if (c == 1) begin
                wr_strobe = 1'b0;
                rd_req    = 1'b0;
            end
            if (c == collide_at)     wr_strobe = 1'b1;
            if (c == collide_at + 1) wr_strobe = 1'b0;
            if (busy)     busy_cycles++;
            if (drop_err) drops++;
            if (ram_req)  req_cycles++;
            if (done) begin
                done_at = c;
                break;
            end
        end
        @(negedge clk);
        if (drop_err) drops++;
        checkOutput("busy_after", 64'(busy), 64'h0);
        if (!we && size != 2'b11 && rdexp_q.size() != 0)
            checkOutput("load_data", data_o, rdexp_q.pop_front());
    endtask

    int d_at, b_cyc, drp, rq;

    initial begin
        reset = 1'b1; wr_strobe = 1'b0; rd_req = 1'b0; mem_size = 2'b10;
        addr = '0; data_i = '0; ram_ack = 1'b0; ram_rdata = '0;
        mem[30'h3] = 32'h4433_2211;
        mem[30'h4] = 32'h8877_6655;
        repeat (2) @(negedge clk);
        checkOutput("reset_outs_a", {data_o, busy, done, drop_err, ram_req, ram_we}, 64'h0);
        checkOutput("reset_outs_b", {ram_addr, ram_be, ram_wdata}, 64'h0);
        reset = 1'b0;

        applyStimulus(1, 0, 2'b10, 32'h100, 32'hDEAD_BEEF, 0, 0, 20, d_at, b_cyc, drp, rq);
        checkOutput("word_st_lat", 64'(d_at), 64'd2);
        checkOutput("word_st_busy", 64'(b_cyc), 64'd2);
        checkOutput("word_st_mem", memRead(30'h40), 32'hDEAD_BEEF);

        applyStimulus(1, 0, 2'b00, 32'h103, 32'h1234_56A5, 0, 0, 20, d_at, b_cyc, drp, rq);
        checkOutput("byte_st_lat", 64'(d_at), 64'd2);
        checkOutput("byte_st_mem", memRead(30'h40), 32'hA5AD_BEEF);

        applyStimulus(0, 0, 2'b10, 32'h0E, 32'h0, 0, 0, 20, d_at, b_cyc, drp, rq);
        checkOutput("mis_ld_lat", 64'(d_at), 64'd3);
        checkOutput("mis_ld_exp", 64'(32'h6655_4433), 64'(data_o));

        applyStimulus(1, 0, 2'b01, 32'hFFFF_FFFF, 32'h0000_BEEF, 0, 0, 20, d_at, b_cyc, drp, rq);
        checkOutput("wrap_st_lat", 64'(d_at), 64'd3);
        checkOutput("wrap_mem_hi", memRead(30'h3FFF_FFFF), 32'hEF00_0000);
        checkOutput("wrap_mem_lo", memRead(30'h0), 32'h0000_00BE);

        applyStimulus(0, 0, 2'b01, 32'hFFFF_FFFF, 32'h0, 0, 0, 20, d_at, b_cyc, drp, rq);
        applyStimulus(0, 0, 2'b00, 32'h103, 32'h0, 0, 0, 20, d_at, b_cyc, drp, rq);
        applyStimulus(0, 0, 2'b01, 32'h102, 32'h0, 0, 0, 20, d_at, b_cyc, drp, rq);

        applyStimulus(1, 0, 2'b10, 32'h200, 32'hCAFE_F00D, 3, 2, 30, d_at, b_cyc, drp, rq);
        checkOutput("wait_st_lat", 64'(d_at), 64'd5);
        checkOutput("collide_drop", 64'(drp), 64'd1);
        checkOutput("wait_req_cycles", 64'(rq), 64'd4);

        applyStimulus(0, 0, 2'b10, 32'h0E, 32'h0, 2, 0, 30, d_at, b_cyc, drp, rq);
        checkOutput("wait_mis_ld_lat", 64'(d_at), 64'd7);

        applyStimulus(1, 1, 2'b01, 32'h300, 32'hFFFF_1234, 0, 0, 20, d_at, b_cyc, drp, rq);
        checkOutput("both_lat", 64'(d_at), 64'd2);
        checkOutput("both_drop", 64'(drp), 64'd1);
        applyStimulus(0, 0, 2'b10, 32'h300, 32'h0, 0, 0, 20, d_at, b_cyc, drp, rq);

        applyStimulus(1, 0, 2'b11, 32'h500, 32'h1111_1111, 0, 0, 5, d_at, b_cyc, drp, rq);
        checkOutput("rsv_no_done", 64'(d_at), -64'sd1);
        checkOutput("rsv_no_req", 64'(rq), 64'd0);
        checkOutput("rsv_drop", 64'(drp), 64'd1);
        checkOutput("queue_empty", 64'(beat_q.size()), 64'd0);

        // Reset during the second beat of a split store
        @(negedge clk);
        ack_delay = 4; mem_size = 2'b10; addr = 32'h401; data_i = 32'h5555_AAAA;
        pushExpected(1, 2'b10, 32'h401, 32'h5555_AAAA);
        wr_strobe = 1'b1;
        d_at = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            wr_strobe = 1'b0;
            if (ram_req && ram_addr == 30'h101) begin
                d_at = c;
                break;
            end
        end
        checkOutput("reached_beat1", 64'(d_at > 0), 64'h1);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_mid_a", {data_o, busy, done, drop_err, ram_req, ram_we}, 64'h0);
        checkOutput("rst_mid_b", {ram_addr, ram_be, ram_wdata}, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        beat_q.delete();
        rq = 0; b_cyc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done || ram_req) rq++;
            if (busy) b_cyc++;
        end
        checkOutput("post_rst_quiet", 64'(rq), 64'd0);
        checkOutput("post_rst_idle", 64'(b_cyc), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
